// File: rtl/shift_issue.sv
// Issue stage for the RV32I shift datapath: decodes shift instructions into
// shifter operands and presents them through a two-entry valid/ready skid buffer.
module shift_issue (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] sh_a,
    output logic [4:0]  sh_shamt,
    output logic [1:0]  sh_shtype,
    output logic [4:0]  sh_rd,
    output logic        sh_illegal
);

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SRX     = 3'b101;
    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;
    localparam logic [1:0] SH_SLL     = 2'b00;
    localparam logic [1:0] SH_SRL     = 2'b01;
    localparam logic [1:0] SH_SRA     = 2'b10;
    localparam logic [1:0] SH_PASS    = 2'b11;

    typedef struct packed {
        logic [31:0] a;
        logic [4:0]  shamt;
        logic [1:0]  shtype;
        logic [4:0]  rd;
        logic        illegal;
    } entry_t;

    localparam entry_t ENTRY_RESET = '{a: 32'h0000_0000, shamt: 5'd0,
                                       shtype: SH_PASS, rd: 5'd0, illegal: 1'b0};

    // Shift type for a funct3/funct7 pair; SH_PASS marks anything that is not a shift.
    function automatic logic [1:0] shift_kind(input logic [2:0] funct3,
                                              input logic [6:0] funct7);
        logic [1:0] kind;
        kind = SH_PASS;
        if (funct3 == F3_SLL && funct7 == F7_BASE) begin
            kind = SH_SLL;
        end else if (funct3 == F3_SRX && funct7 == F7_BASE) begin
            kind = SH_SRL;
        end else if (funct3 == F3_SRX && funct7 == F7_ALT) begin
            kind = SH_SRA;
        end else begin
            kind = SH_PASS;
        end
        return kind;
    endfunction

    entry_t main_r;
    entry_t skid_r;
    logic   main_valid_r;
    logic   skid_valid_r;
    entry_t dec_s;
    logic [1:0] kind_s;
    logic   in_fire_s;
    logic   out_fire_s;
    logic   main_free_s;

    // Instruction decode into a candidate buffer entry.
    always_comb begin
        dec_s         = ENTRY_RESET;
        dec_s.a       = rs1_data;
        dec_s.rd      = instr[11:7];
        kind_s        = shift_kind(instr[14:12], instr[31:25]);
        case (instr[6:0])
            OPC_OP_IMM: begin
                if (kind_s != SH_PASS) begin
                    dec_s.shtype  = kind_s;
                    dec_s.shamt   = instr[24:20];
                    dec_s.illegal = 1'b0;
                end else begin
                    dec_s.shtype  = SH_PASS;
                    dec_s.shamt   = 5'd0;
                    dec_s.illegal = 1'b1;
                end
            end
            OPC_OP: begin
                if (kind_s != SH_PASS) begin
                    dec_s.shtype  = kind_s;
                    dec_s.shamt   = rs2_data[4:0];
                    dec_s.illegal = 1'b0;
                end else begin
                    dec_s.shtype  = SH_PASS;
                    dec_s.shamt   = 5'd0;
                    dec_s.illegal = 1'b1;
                end
            end
            default: begin
                dec_s.shtype  = SH_PASS;
                dec_s.shamt   = 5'd0;
                dec_s.illegal = 1'b1;
            end
        endcase
    end

    // Handshake qualifiers; in_ready depends only on the skid register.
    always_comb begin
        in_fire_s   = in_valid & ~skid_valid_r;
        out_fire_s  = main_valid_r & out_ready;
        main_free_s = ~main_valid_r | out_ready;
    end

    // Main/skid buffer state; flush only clears the valid bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            main_r       <= ENTRY_RESET;
            skid_r       <= ENTRY_RESET;
            main_valid_r <= 1'b0;
            skid_valid_r <= 1'b0;
        end else if (flush) begin
            main_valid_r <= 1'b0;
            skid_valid_r <= 1'b0;
        end else if (main_free_s) begin
            if (skid_valid_r) begin
                main_r       <= skid_r;
                main_valid_r <= 1'b1;
                skid_valid_r <= 1'b0;
            end else if (in_fire_s) begin
                main_r       <= dec_s;
                main_valid_r <= 1'b1;
            end else begin
                main_valid_r <= 1'b0;
            end
        end else begin
            if (in_fire_s) begin
                skid_r       <= dec_s;
                skid_valid_r <= 1'b1;
            end else begin
                skid_valid_r <= skid_valid_r;
            end
        end
    end

    assign in_ready   = ~skid_valid_r;
    assign out_valid  = main_valid_r;
    assign sh_a       = main_r.a;
    assign sh_shamt   = main_r.shamt;
    assign sh_shtype  = main_r.shtype;
    assign sh_rd      = main_r.rd;
    assign sh_illegal = main_r.illegal;

endmodule

// File: tb/tb_shift_issue.sv
// Directed bench for shift_issue: decode results, skid buffering, flush and reset.
module tb_shift_issue;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sh_a;
    logic [4:0]  sh_shamt;
    logic [1:0]  sh_shtype;
    logic [4:0]  sh_rd;
    logic        sh_illegal;

    int errors = 0;
    int checks = 0;

    shift_issue dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .sh_a(sh_a), .sh_shamt(sh_shamt), .sh_shtype(sh_shtype),
        .sh_rd(sh_rd), .sh_illegal(sh_illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] i, input logic [31:0] r1, input logic [31:0] r2);
        in_valid = 1'b1;
        instr    = i;
        rs1_data = r1;
        rs2_data = r2;
    endtask

    task automatic check_entry(input string tag, input logic [31:0] a, input logic [4:0] shamt,
                               input logic [1:0] shtype, input logic [4:0] rd, input logic ill);
        check({tag, ".valid"},   {31'd0, out_valid}, 32'd1);
        check({tag, ".a"},       sh_a, a);
        check({tag, ".shamt"},   {27'd0, sh_shamt}, {27'd0, shamt});
        check({tag, ".shtype"},  {30'd0, sh_shtype}, {30'd0, shtype});
        check({tag, ".rd"},      {27'd0, sh_rd}, {27'd0, rd});
        check({tag, ".illegal"}, {31'd0, sh_illegal}, {31'd0, ill});
    endtask

    task automatic check_reset(input string tag);
        check({tag, ".out_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, ".in_ready"},  {31'd0, in_ready}, 32'd1);
        check({tag, ".a"},         sh_a, 32'd0);
        check({tag, ".shamt"},     {27'd0, sh_shamt}, 32'd0);
        check({tag, ".shtype"},    {30'd0, sh_shtype}, 32'd3);
        check({tag, ".rd"},        {27'd0, sh_rd}, 32'd0);
        check({tag, ".illegal"},   {31'd0, sh_illegal}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        instr = 32'h0000_0000; rs1_data = 32'h0000_0000; rs2_data = 32'h0000_0000;
        step();
        step();
        check_reset("reset");
        rst = 1'b0;

        // SLLI x5,x1,3 then SRA x7,x2,x3 back-to-back
        send(32'h0030_9293, 32'h0000_00F0, 32'h0000_0000);
        step();
        check_entry("slli", 32'h0000_00F0, 5'd3, 2'b00, 5'd5, 1'b0);
        send(32'h4031_53B3, 32'h8000_0000, 32'hFFFF_FFE4);
        step();
        check_entry("sra", 32'h8000_0000, 5'd4, 2'b10, 5'd7, 1'b0);
        in_valid = 1'b0;
        step();
        check("drain.valid", {31'd0, out_valid}, 32'd0);

        // Stall: SRLI x6,x1,2 into main, SLLI x8,x2,7 into skid
        out_ready = 1'b0;
        send(32'h0020_D313, 32'h1111_1111, 32'h0000_0000);
        step();
        check_entry("stall.srli", 32'h1111_1111, 5'd2, 2'b01, 5'd6, 1'b0);
        check("stall.ready1", {31'd0, in_ready}, 32'd1);
        send(32'h0071_1413, 32'h2222_2222, 32'h0000_0000);
        step();
        check("stall.ready2", {31'd0, in_ready}, 32'd0);
        check_entry("stall.hold1", 32'h1111_1111, 5'd2, 2'b01, 5'd6, 1'b0);
        in_valid = 1'b0;
        step();
        check_entry("stall.hold2", 32'h1111_1111, 5'd2, 2'b01, 5'd6, 1'b0);
        out_ready = 1'b1;
        step();
        check_entry("stall.slli", 32'h2222_2222, 5'd7, 2'b00, 5'd8, 1'b0);
        step();
        check("stall.empty", {31'd0, out_valid}, 32'd0);

        // Illegal encodings: ADD, and SLLI with instr[25]=1
        send(32'h0020_81B3, 32'hABCD_0123, 32'h0000_0005);
        step();
        check_entry("add", 32'hABCD_0123, 5'd0, 2'b11, 5'd3, 1'b1);
        send(32'h0220_9293, 32'h55AA_55AA, 32'h0000_0003);
        step();
        check_entry("slli25", 32'h55AA_55AA, 5'd0, 2'b11, 5'd5, 1'b1);
        in_valid = 1'b0;
        step();

        // Flush with both entries full and in_valid high
        out_ready = 1'b0;
        send(32'h0030_9293, 32'h0000_0001, 32'h0000_0000);
        step();
        send(32'h0020_D313, 32'h0000_0002, 32'h0000_0000);
        step();
        check("flush.full", {31'd0, in_ready}, 32'd0);
        flush = 1'b1;
        send(32'h0071_1413, 32'h0000_0003, 32'h0000_0000);
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush.out_valid", {31'd0, out_valid}, 32'd0);
        check("flush.in_ready", {31'd0, in_ready}, 32'd1);
        step();
        check("flush.dropped", {31'd0, out_valid}, 32'd0);

        // Flush while in_ready is high: the accepted input must be dropped
        send(32'h0030_9293, 32'h0000_0004, 32'h0000_0000);
        step();
        flush = 1'b1;
        send(32'h0020_D313, 32'h0000_0005, 32'h0000_0000);
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush2.out_valid", {31'd0, out_valid}, 32'd0);
        step();
        check("flush2.dropped", {31'd0, out_valid}, 32'd0);
        check("flush2.in_ready", {31'd0, in_ready}, 32'd1);

        // Reset with both entries full under stall
        send(32'h0030_9293, 32'h0000_0006, 32'h0000_0000);
        step();
        send(32'h4031_53B3, 32'h0000_0007, 32'h0000_0001);
        step();
        check("rst.full", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        check_reset("rst2");
        rst = 1'b0;
        step();
        check("rst2.stay_empty", {31'd0, out_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/shift_issue.md
# shift_issue

Issue stage for the RV32I shift datapath. Decodes an instruction word plus register-file operands into shifter operands: value, 5-bit shift amount, and 2-bit shift type. Presents them through a 2-entry valid/ready skid buffer to the combinational shifter that sits directly downstream. Non-shift or reserved encodings are flagged illegal and issued as pass-through.

## Interface
- No parameters; all widths fixed for RV32I.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- flush  in  1  synchronous; drops all buffered entries
- in_valid  in  1  upstream offers an instruction
- in_ready  out  1  stage can accept this cycle
- instr  in  32  instruction word
- rs1_data  in  32  rs1 register value
- rs2_data  in  32  rs2 register value
- out_valid  out  1  sh_* fields valid
- out_ready  in  1  downstream accepts this cycle
- sh_a  out  32  value to shift (= rs1_data)
- sh_shamt  out  5  shift amount
- sh_shtype  out  2  00 SLL, 01 SRL, 10 SRA, 11 pass-through
- sh_rd  out  5  destination register, instr[11:7]
- sh_illegal  out  1  entry is not a legal RV32I shift

## Operation
- Decode is combinational on instr, then registered.
  - opcode 0010011 (OP-IMM), funct3 001, instr[31:25]=0000000: SLLI, shamt=instr[24:20], type 00.
  - OP-IMM, funct3 101, instr[31:25]=0000000: SRLI, type 01. instr[31:25]=0100000: SRAI, type 10.
  - opcode 0110011 (OP), funct3 001, funct7=0000000: SLL, shamt=rs2_data[4:0], type 00.
  - OP, funct3 101: funct7 0000000 is SRL (type 01); 0100000 is SRA (type 10).
  - Anything else, including OP-IMM shifts with instr[25]=1: type 11, shamt 0, sh_illegal=1.
- sh_a is always rs1_data, and sh_rd is always instr[11:7], illegal or not.
- Two storage entries: main (drives outputs) and skid.
  - in_ready = !skid_valid. It comes straight from a register, with no combinational path from out_ready.
  - in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Update when main is free (main empty or out_fire):
  - If skid_valid: main <= skid, skid_valid <= 0.
  - Else if in_fire: main <= decoded input.
  - Else: main_valid <= 0.
- Update when main is held (out_valid & !out_ready): if in_fire, skid <= decoded input and skid_valid <= 1.
- Order is strictly preserved. No entry is duplicated or lost except on flush or rst.
- flush: main_valid and skid_valid <= 0 next cycle. Any in_fire in the same cycle is dropped. Data registers are unchanged.

## Timing
- Reset values: out_valid 0, in_ready 1, sh_a 0, sh_shamt 0, sh_shtype 11, sh_rd 0, sh_illegal 0, skid_valid 0.
- rst takes priority over flush and over all handshakes.
- Latency: an instruction accepted at edge N is on the outputs with out_valid=1 after edge N (cycle N+1).
- Throughput: one per cycle while out_ready stays high.
- On the first stalled cycle, one more input may be taken into skid. in_ready then falls the cycle after.
- When out_ready rises with skid full:
  - skid moves to main on that edge.
  - in_ready rises one cycle later.
  - No bubble appears on the output.
- Outputs hold stable while out_valid & !out_ready.
- Simultaneous flush and out_fire: the out transfer completes. Both entries are then empty.

## Test plan
- Reset, then in_valid with instr SLLI x5,x1,3 (0x00309293) and rs1=0x0000_00F0. Required next cycle: out_valid=1, sh_a=0xF0, shamt=3, shtype=00, rd=5, illegal=0.
- SRA x7,x2,x3 (0x403153B3) with rs1=0x8000_0000 and rs2=0xFFFF_FFE4. Required: shamt=4 (low 5 bits only), shtype=10.
- Stall: hold out_ready=0 and send SRLI then SLLI back-to-back.
  - in_ready must drop after the second accept.
  - Output holds SRLI.
  - After out_ready=1, SRLI and then SLLI appear on consecutive cycles with no loss.
- ADD (0x002081B3) and SLLI with instr[25]=1 (0x0220_9293). Required for each: shtype=11, shamt=0, illegal=1, sh_a=rs1.
- Fill both entries under stall, then pulse flush with in_valid=1. Required next cycle: out_valid=0, in_ready=1, and the flush-cycle input dropped.
- Assert rst while both entries are full and out_ready=0. Required next cycle: all outputs at reset values.
